// File: rtl/stream_min_max_if.sv
// Handshake bundle for stream_min_max: sample input stream and frame result port.
// STREAM_MIN_MAX_INDEX_EN adds the min/max beat-position signals.
interface stream_min_max_if #(
    parameter int N       = 32,
    parameter int COUNT_W = 16
);
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] out_min;
    logic signed [N-1:0] out_max;
    logic [COUNT_W-1:0]  out_count;
`ifdef STREAM_MIN_MAX_INDEX_EN
    logic [COUNT_W-1:0]  out_min_idx;
    logic [COUNT_W-1:0]  out_max_idx;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_min, out_max, out_count, out_min_idx, out_max_idx
    );
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_min, out_max, out_count, out_min_idx, out_max_idx
    );
`else
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_min, out_max, out_count
    );
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_min, out_max, out_count
    );
`endif
endinterface

// File: rtl/stream_min_max.sv
// Per-frame signed min/max/beat-count reduction over a valid/ready stream.
// STREAM_MIN_MAX_INDEX_EN adds first-occurrence beat positions of min and max.

// Signed a < b; the sign-extended difference cannot overflow, so mixed-sign extremes are safe.
module comparator_lt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);
    logic [N:0] diff;
    assign diff = {a[N-1], a} - {b[N-1], b};
    assign lt   = diff[N];
endmodule

module stream_min_max #(
    parameter int N       = 32,
    parameter int COUNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    stream_min_max_if.slave s
);
    typedef enum logic [1:0] {FIRST, ACCUM, DONE} state_t;

    state_t              state;
    logic signed [N-1:0] min_r, max_r;
    logic [COUNT_W-1:0]  cnt_r;
    logic                in_ready_r, out_valid_r;
    logic                lt_min, gt_max, accept;
    logic [COUNT_W-1:0]  cnt_inc;

    comparator_lt #(.N(N)) u_lt_min (.a(s.in_data), .b(min_r),     .lt(lt_min));
    comparator_lt #(.N(N)) u_gt_max (.a(max_r),     .b(s.in_data), .lt(gt_max));

    assign accept  = s.in_valid & in_ready_r;
    assign cnt_inc = (&cnt_r) ? cnt_r : cnt_r + 1'b1;

`ifdef STREAM_MIN_MAX_INDEX_EN
    logic [COUNT_W-1:0] min_idx_r, max_idx_r;

    // Position is the pre-increment count, so it pins at all-ones once the count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_idx_r <= '0;
            max_idx_r <= '0;
        end else if (accept) begin
            if (state == FIRST) begin
                min_idx_r <= '0;
                max_idx_r <= '0;
            end else begin
                if (lt_min) min_idx_r <= cnt_r;
                if (gt_max) max_idx_r <= cnt_r;
            end
        end
    end

    assign s.out_min_idx = min_idx_r;
    assign s.out_max_idx = max_idx_r;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FIRST;
            min_r       <= '0;
            max_r       <= '0;
            cnt_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                FIRST: if (accept) begin
                    min_r <= s.in_data;
                    max_r <= s.in_data;
                    cnt_r <= COUNT_W'(1);
                    if (s.in_last) begin
                        state       <= DONE;
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                    end else begin
                        state <= ACCUM;
                    end
                end
                ACCUM: if (accept) begin
                    // Strict compares: ties keep the earliest occurrence.
                    if (lt_min) min_r <= s.in_data;
                    if (gt_max) max_r <= s.in_data;
                    cnt_r <= cnt_inc;
                    if (s.in_last) begin
                        state       <= DONE;
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: if (s.out_ready) begin
                    state       <= FIRST;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
                default: begin
                    state       <= FIRST;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign s.in_ready  = in_ready_r;
    assign s.out_valid = out_valid_r;
    assign s.out_min   = min_r;
    assign s.out_max   = max_r;
    assign s.out_count = cnt_r;
endmodule

// File: tb/tb_stream_min_max.sv
// Directed bench for stream_min_max: default-width DUT plus a COUNT_W=2 DUT for saturation.
module tb_stream_min_max;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_min_max_if #(.N(32), .COUNT_W(16)) b1 ();
    stream_min_max_if #(.N(32), .COUNT_W(2))  b2 ();

    stream_min_max #(.N(32), .COUNT_W(16)) dut  (.clk(clk), .rst(rst), .s(b1.slave));
    stream_min_max #(.N(32), .COUNT_W(2))  dut2 (.clk(clk), .rst(rst), .s(b2.slave));

    task automatic send_beat(input logic signed [31:0] d, input logic l);
        logic r;
        int n;
        n = 0;
        b1.in_valid = 1'b1; b1.in_data = d; b1.in_last = l;
        do begin
            @(negedge clk); r = b1.in_ready;
            @(posedge clk); #1; n++;
        end while (!r && n < 50);
        b1.in_valid = 1'b0;
        if (!r) begin errors++; $display("FAIL send_beat timeout data=%0d", d); end
    endtask

    task automatic send_beat2(input logic signed [31:0] d, input logic l);
        logic r;
        int n;
        n = 0;
        b2.in_valid = 1'b1; b2.in_data = d; b2.in_last = l;
        do begin
            @(negedge clk); r = b2.in_ready;
            @(posedge clk); #1; n++;
        end while (!r && n < 50);
        b2.in_valid = 1'b0;
        if (!r) begin errors++; $display("FAIL send_beat2 timeout data=%0d", d); end
    endtask

    task automatic test_reset();
        #12;
        checks += 5;
        if (b1.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready got %b want 1", b1.in_ready); end
        if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", b1.out_valid); end
        if (b1.out_min !== 32'sd0) begin errors++; $display("FAIL rst_min got %0d want 0", b1.out_min); end
        if (b1.out_max !== 32'sd0) begin errors++; $display("FAIL rst_max got %0d want 0", b1.out_max); end
        if (b1.out_count !== 16'd0) begin errors++; $display("FAIL rst_count got %0d want 0", b1.out_count); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        b1.out_ready = 1'b1;
        send_beat(5, 0); send_beat(-3, 0); send_beat(7, 0); send_beat(0, 1);
        checks += 5;
        if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", b1.out_valid); end
        if (b1.in_ready !== 1'b0)  begin errors++; $display("FAIL basic_in_ready got %b want 0", b1.in_ready); end
        if (b1.out_min !== -32'sd3) begin errors++; $display("FAIL basic_min got %0d want -3", b1.out_min); end
        if (b1.out_max !== 32'sd7)  begin errors++; $display("FAIL basic_max got %0d want 7", b1.out_max); end
        if (b1.out_count !== 16'd4) begin errors++; $display("FAIL basic_count got %0d want 4", b1.out_count); end
        @(posedge clk); #1;
        checks += 2;
        if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", b1.out_valid); end
        if (b1.in_ready !== 1'b1)  begin errors++; $display("FAIL basic_ready_back got %b want 1", b1.in_ready); end
    endtask

    task automatic test_extremes();
        b1.out_ready = 1'b1;
        send_beat(32'sh80000000, 1);
        checks += 3;
        if (b1.out_min !== 32'h80000000) begin errors++; $display("FAIL ext1_min got %h want 80000000", b1.out_min); end
        if (b1.out_max !== 32'h80000000) begin errors++; $display("FAIL ext1_max got %h want 80000000", b1.out_max); end
        if (b1.out_count !== 16'd1) begin errors++; $display("FAIL ext1_count got %0d want 1", b1.out_count); end
`ifdef STREAM_MIN_MAX_INDEX_EN
        checks += 2;
        if (b1.out_min_idx !== 16'd0) begin errors++; $display("FAIL ext1_min_idx got %0d want 0", b1.out_min_idx); end
        if (b1.out_max_idx !== 16'd0) begin errors++; $display("FAIL ext1_max_idx got %0d want 0", b1.out_max_idx); end
`endif
        @(posedge clk); #1;
        send_beat(32'sh7FFFFFFF, 0); send_beat(32'sh80000000, 1);
        checks += 3;
        if (b1.out_min !== 32'h80000000) begin errors++; $display("FAIL ext2_min got %h want 80000000", b1.out_min); end
        if (b1.out_max !== 32'h7FFFFFFF) begin errors++; $display("FAIL ext2_max got %h want 7fffffff", b1.out_max); end
        if (b1.out_count !== 16'd2) begin errors++; $display("FAIL ext2_count got %0d want 2", b1.out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_ties();
        b1.out_ready = 1'b1;
        send_beat(4, 0); send_beat(4, 0); send_beat(1, 0);
        send_beat(9, 0); send_beat(1, 0); send_beat(9, 1);
        checks += 3;
        if (b1.out_min !== 32'sd1) begin errors++; $display("FAIL ties_min got %0d want 1", b1.out_min); end
        if (b1.out_max !== 32'sd9) begin errors++; $display("FAIL ties_max got %0d want 9", b1.out_max); end
        if (b1.out_count !== 16'd6) begin errors++; $display("FAIL ties_count got %0d want 6", b1.out_count); end
`ifdef STREAM_MIN_MAX_INDEX_EN
        checks += 2;
        if (b1.out_min_idx !== 16'd2) begin errors++; $display("FAIL ties_min_idx got %0d want 2", b1.out_min_idx); end
        if (b1.out_max_idx !== 16'd3) begin errors++; $display("FAIL ties_max_idx got %0d want 3", b1.out_max_idx); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic signed [31:0] v [6];
        v = '{12, -5, 30, -5, 30, 2};
        b1.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin @(posedge clk); #1; end
            send_beat(v[i], i == 5);
        end
        // Offer a beat of the next frame while the result is still pending.
        b1.in_valid = 1'b1; b1.in_data = 100; b1.in_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks += 5;
            if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d got %b want 1", c, b1.out_valid); end
            if (b1.in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready cyc%0d got %b want 0", c, b1.in_ready); end
            if (b1.out_min !== -32'sd5) begin errors++; $display("FAIL bp_min cyc%0d got %0d want -5", c, b1.out_min); end
            if (b1.out_max !== 32'sd30) begin errors++; $display("FAIL bp_max cyc%0d got %0d want 30", c, b1.out_max); end
            if (b1.out_count !== 16'd6) begin errors++; $display("FAIL bp_count cyc%0d got %0d want 6", c, b1.out_count); end
        end
`ifdef STREAM_MIN_MAX_INDEX_EN
        checks += 2;
        if (b1.out_min_idx !== 16'd1) begin errors++; $display("FAIL bp_min_idx got %0d want 1", b1.out_min_idx); end
        if (b1.out_max_idx !== 16'd2) begin errors++; $display("FAIL bp_max_idx got %0d want 2", b1.out_max_idx); end
`endif
        b1.out_ready = 1'b1;
        @(posedge clk); #1;
        b1.out_ready = 1'b0;
        checks += 2;
        if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL bp_hs_valid got %b want 0", b1.out_valid); end
        if (b1.in_ready !== 1'b1)  begin errors++; $display("FAIL bp_hs_ready got %b want 1", b1.in_ready); end
        send_beat(100, 0); send_beat(-1, 1);
        checks += 3;
        if (b1.out_min !== -32'sd1)  begin errors++; $display("FAIL bp_next_min got %0d want -1", b1.out_min); end
        if (b1.out_max !== 32'sd100) begin errors++; $display("FAIL bp_next_max got %0d want 100", b1.out_max); end
        if (b1.out_count !== 16'd2)  begin errors++; $display("FAIL bp_next_count got %0d want 2", b1.out_count); end
        b1.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_saturate();
        b2.out_ready = 1'b1;
        send_beat2(1, 0); send_beat2(2, 0); send_beat2(3, 0);
        send_beat2(4, 0); send_beat2(-50, 0); send_beat2(60, 1);
        checks += 3;
        if (b2.out_min !== -32'sd50) begin errors++; $display("FAIL sat_min got %0d want -50", b2.out_min); end
        if (b2.out_max !== 32'sd60)  begin errors++; $display("FAIL sat_max got %0d want 60", b2.out_max); end
        if (b2.out_count !== 2'd3)   begin errors++; $display("FAIL sat_count got %0d want 3", b2.out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        b1.out_ready = 1'b1;
        send_beat(3, 0); send_beat(-8, 0);
        #2 rst = 1'b1;
        #1;
        checks += 5;
        if (b1.out_min !== 32'sd0)  begin errors++; $display("FAIL mrst_min got %0d want 0", b1.out_min); end
        if (b1.out_max !== 32'sd0)  begin errors++; $display("FAIL mrst_max got %0d want 0", b1.out_max); end
        if (b1.out_count !== 16'd0) begin errors++; $display("FAIL mrst_count got %0d want 0", b1.out_count); end
        if (b1.out_valid !== 1'b0)  begin errors++; $display("FAIL mrst_valid got %b want 0", b1.out_valid); end
        if (b1.in_ready !== 1'b1)   begin errors++; $display("FAIL mrst_ready got %b want 1", b1.in_ready); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        send_beat(10, 1);
        checks += 3;
        if (b1.out_min !== 32'sd10) begin errors++; $display("FAIL mrst_next_min got %0d want 10", b1.out_min); end
        if (b1.out_max !== 32'sd10) begin errors++; $display("FAIL mrst_next_max got %0d want 10", b1.out_max); end
        if (b1.out_count !== 16'd1) begin errors++; $display("FAIL mrst_next_count got %0d want 1", b1.out_count); end
        @(posedge clk); #1;
    endtask

    initial begin
        b1.in_valid = 1'b0; b1.in_data = '0; b1.in_last = 1'b0; b1.out_ready = 1'b0;
        b2.in_valid = 1'b0; b2.in_data = '0; b2.in_last = 1'b0; b2.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_extremes();
        test_ties();
        test_backpressure();
        test_saturate();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
